// File: rtl/z80_bus_monitor.sv
// z80_bus_monitor
//
// Passive bus-cycle recorder for the tv80s core. Each posedge sample of the CPU
// strobes is classified, and consecutive samples of the same class are merged
// into one record (class, last address, last data, first-sample timestamp).
// When a record closes it is pushed into a first-word-fall-through FIFO.
//
// Optional feature macro: Z80_BUS_MONITOR_RFSH_EN
//   defined   - refresh samples (mreq_n & rfsh_n low) are recorded as type 6, data 0x00
//   undefined - refresh samples classify as idle
//
// Parameters:
//   DEPTH  FIFO records (power of two, >= 2)
//   AW     log2(DEPTH)
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   m1_n, mreq_n, iorq_n, rd_n,
//   wr_n, rfsh_n                     CPU strobes, active-low
//   A, di, dout                      address bus, data into CPU, data from CPU
//   rec_ready                        pop the head record
//   clear_ovf                        clear the overflow flag
//   rec_valid                        FIFO not empty
//   rec_type/addr/data/time          head record fields (0 while empty)
//   count                            records held
//   overflow                         sticky: a record was dropped
module z80_bus_monitor #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m1_n,
    input  logic          mreq_n,
    input  logic          iorq_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          rfsh_n,
    input  logic [15:0]   A,
    input  logic [7:0]    di,
    input  logic [7:0]    dout,
    input  logic          rec_ready,
    input  logic          clear_ovf,
    output logic          rec_valid,
    output logic [2:0]    rec_type,
    output logic [15:0]   rec_addr,
    output logic [7:0]    rec_data,
    output logic [15:0]   rec_time,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [2:0] {
        CY_FETCH = 3'd0,
        CY_MRD   = 3'd1,
        CY_MWR   = 3'd2,
        CY_IORD  = 3'd3,
        CY_IOWR  = 3'd4,
        CY_INTA  = 3'd5,
        CY_RFSH  = 3'd6,
        CY_IDLE  = 3'd7
    } cycle_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    localparam int REC_W = 3 + 16 + 8 + 16;

    state_t       state, state_next;
    cycle_t       sample_cls;
    logic [7:0]   sample_data;
    cycle_t       cur_cls;
    logic [15:0]  cur_addr;
    logic [7:0]   cur_data;
    logic [15:0]  cur_time;
    logic [15:0]  tstamp;
    logic         push;
    logic         open_new;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count_q;
    logic             pop, full, push_ok, drop;
    logic [REC_W-1:0] head;

    // ---------------------------------------------------------------
    // Sample classification (priority order)
    // ---------------------------------------------------------------
    always_comb begin
        sample_cls = CY_IDLE;
        if (!m1_n && !mreq_n && !rd_n)
            sample_cls = CY_FETCH;
        else if (!m1_n && !iorq_n)
            sample_cls = CY_INTA;
        else if (!mreq_n && !rd_n)
            sample_cls = CY_MRD;
        else if (!mreq_n && !wr_n)
            sample_cls = CY_MWR;
        else if (!iorq_n && !rd_n)
            sample_cls = CY_IORD;
        else if (!iorq_n && !wr_n)
            sample_cls = CY_IOWR;
`ifdef Z80_BUS_MONITOR_RFSH_EN
        else if (!mreq_n && !rfsh_n)
            sample_cls = CY_RFSH;
`endif
    end

`ifndef Z80_BUS_MONITOR_RFSH_EN
    logic unused_rfsh;
    assign unused_rfsh = rfsh_n;
`endif

    always_comb begin
        sample_data = 8'h00;
        case (sample_cls)
            CY_MWR, CY_IOWR:                    sample_data = dout;
            CY_FETCH, CY_INTA, CY_MRD, CY_IORD: sample_data = di;
            default:                            sample_data = 8'h00;
        endcase
    end

    // ---------------------------------------------------------------
    // Capture FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        push       = 1'b0;
        open_new   = 1'b0;
        case (state)
            ST_IDLE: begin
                open_new = (sample_cls != CY_IDLE);
            end
            ST_ACTIVE: begin
                // Idle or a class change closes the record; a class change
                // also opens the next one on the same sample.
                push     = (sample_cls != cur_cls);
                open_new = (sample_cls != cur_cls) && (sample_cls != CY_IDLE);
            end
            default: ;
        endcase
        if (sample_cls != CY_IDLE)
            state_next = ST_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_cls  <= CY_IDLE;
            cur_addr <= '0;
            cur_data <= '0;
            cur_time <= '0;
        end else if (sample_cls != CY_IDLE) begin
            cur_addr <= A;
            cur_data <= sample_data;
            if (open_new) begin
                cur_cls  <= sample_cls;
                cur_time <= tstamp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            tstamp <= '0;
        else
            tstamp <= tstamp + 16'd1;
    end

    // ---------------------------------------------------------------
    // Record FIFO
    // ---------------------------------------------------------------
    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid && rec_ready;
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {cur_cls, cur_addr, cur_data, cur_time};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

    assign head     = rec_valid ? mem[rd_ptr] : '0;
    assign rec_type = head[42:40];
    assign rec_addr = head[39:24];
    assign rec_data = head[23:16];
    assign rec_time = head[15:0];
    assign count    = count_q;

endmodule

// File: doc/z80_bus_monitor.md
# z80_bus_monitor

Passive bus-cycle recorder that sits directly downstream of the tv80s core. It watches the CPU control strobes, address and both data buses, and classifies each completed bus cycle: opcode fetch, memory read/write, I/O read/write, interrupt acknowledge, or optionally refresh. Each completed cycle becomes one record in an internal first-word-fall-through FIFO. Benches and the debug path drain the FIFO to check instruction-level bus traffic without probing memory arrays.

## Interface
- `DEPTH`, 16: number of FIFO records; must be a power of two, at least 2.
- `AW`, 4: log2(`DEPTH`).
- `clk` in 1: CPU clock; all sampling is on the posedge.
- `reset` in 1: synchronous, active-high.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n` in 1 each: CPU strobes, active-low.
- `A` in 16: CPU address bus.
- `di` in 8: data returned to the CPU.
- `dout` in 8: data driven by the CPU.
- `rec_ready` in 1: consumer pops the head record.
- `clear_ovf` in 1: clears `overflow`.
- `rec_valid` out 1: FIFO is not empty.
- `rec_type` out 3: cycle class of the head record.
  - 0 FETCH, 1 MRD, 2 MWR, 3 IORD, 4 IOWR, 5 INTA, 6 RFSH.
- `rec_addr` out 16, `rec_data` out 8, `rec_time` out 16: address, data and timestamp of the head record.
- `count` out AW+1: number of records held.
- `overflow` out 1: sticky flag, set when a record is dropped.

## Operation
- Classification of each sample, in priority order:
  - `!m1_n & !mreq_n & !rd_n` gives FETCH.
  - `!m1_n & !iorq_n` gives INTA.
  - `!mreq_n & !rd_n` gives MRD.
  - `!mreq_n & !wr_n` gives MWR.
  - `!iorq_n & !rd_n` gives IORD.
  - `!iorq_n & !wr_n` gives IOWR.
  - `!mreq_n & !rfsh_n` gives RFSH (only when the macro is defined).
  - Anything else is idle.
- Capture state machine with two states:
  - IDLE: on a non-idle sample, go to ACTIVE. Latch the class, `A`, and the `tstamp` value at that sample.
  - ACTIVE: on every sample with the same class, update the data latch and re-latch `A`.
    - Read classes and FETCH/INTA latch `di`; write classes latch `dout`; RFSH latches 0x00.
  - A sample that is idle, or that has a different class, closes the record and pushes it.
    - A different class also opens a new record in the same cycle, so FETCH followed directly by RFSH produces two records.
- The pushed data is the last value latched while the class was active.
- `tstamp` is a free-running 16-bit counter, cleared by reset, that wraps 0xFFFF to 0x0000 silently.
- FIFO:
  - A push is accepted if `count < DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the record is dropped and `overflow` is set.
  - A pop happens when `rec_valid & rec_ready`; `rec_ready` while empty is ignored.
  - Simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo `DEPTH`.
- `overflow` clears on `clear_ovf`. If a drop and `clear_ovf` occur in the same cycle, the drop wins and the flag stays set.

## Timing
- Reset values:
  - `rec_valid`=0, `count`=0, `overflow`=0.
  - `rec_type`/`rec_addr`/`rec_data`/`rec_time` are 0 while empty.
  - FSM returns to IDLE and the in-flight record is discarded.
- A strobe that is still active when `reset` deasserts is recorded; its timestamp is that of the first post-reset sample.
- Latency: the record is written on the edge that samples the closing condition, and `rec_valid` rises in the following cycle.
- Head outputs change only on a pop, or on a push into an empty FIFO.
- `count` updates on the same edge as the push or pop.
- Records closed on back-to-back edges are all accepted; the monitor sustains one push per clock.

## Configuration
- `Z80_BUS_MONITOR_RFSH_EN`:
  - Defined: refresh cycles are recorded as type 6, with `rec_addr` set to the refresh address and `rec_data` set to 0x00.
  - Undefined: refresh samples classify as idle, and type 6 is never produced.

## Test plan
- CALL NZ with the macro undefined:
  - Setup: mem 0000=C4, 0001=61, 0002=9C; F=0x0E; SP=5698; PC=0000; `rec_ready` held high into a logger.
  - Required records, in order:
    - FETCH 0000/C4
    - MRD 0001/61
    - MRD 0002/9C
    - MWR 5697/00
    - MWR 5696/03
    - FETCH 9C61
  - Timestamps strictly increasing.
- Same program with the macro defined: a RFSH record with data 00 follows each FETCH. The other records are unchanged.
- OUT (0x12),A with A=0x5A, then IN A,(0x12): expect IOWR 5A12/5A, then IORD with `rec_addr[7:0]`=12.
- With `rec_ready`=0, run 20 cycles of traffic:
  - `count` saturates at 16 and `overflow`=1.
  - The first 16 records are intact.
  - `clear_ovf` drops `overflow` to 0.
- With `count`=16, pulse `rec_ready` for one cycle in the same cycle as a push: `count` stays 16 and `overflow` stays 0.
- Assert `reset` mid-MWR with `count`=3: the next cycle shows `count`=0 and `rec_valid`=0, no partial record appears, and `tstamp` restarts from 0.
